// File: rtl/serial_word_adder_driver.sv
// Word-level front end for an external bit-serial adder: LSB-first operand streaming and sum collection.
// Optional signed overflow flag output enabled by defining SERIAL_WORD_ADDER_OVF_EN.
module serial_word_adder_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ser_rst,
  output logic             ser_a,
  output logic             ser_b,
  input  logic             ser_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
`ifdef SERIAL_WORD_ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH:0]   col;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == CNT_W'(WIDTH)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands shift right with zero fill, so bit 0 is the current bit and is 0 on the flush cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr <= in_a;
            b_sr <= in_b;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          col  <= {ser_sum, col[WIDTH:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          if (cnt != CNT_W'(WIDTH)) cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign ser_rst   = rst | (state != SHIFT);
  assign ser_a     = (state == SHIFT) & a_sr[0];
  assign ser_b     = (state == SHIFT) & b_sr[0];
  assign out_sum   = col[WIDTH-1:0];
  assign out_carry = col[WIDTH];

`ifdef SERIAL_WORD_ADDER_OVF_EN
  logic a_sign, b_sign;

  function automatic logic ovf_flag(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

  // Operand signs are kept aside because the shift registers are consumed during SHIFT
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sign <= 1'b0;
      b_sign <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_sign <= in_a[WIDTH-1];
      b_sign <= in_b[WIDTH-1];
    end
  end

  assign out_ovf = (state == DONE) & ovf_flag(a_sign, b_sign, col[WIDTH-1]);
`endif

endmodule

// File: tb/tb_serial_word_adder_driver.sv
// Scoreboard bench for serial_word_adder_driver with a behavioural bit-serial adder attached.
module tb_serial_word_adder_driver;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         ser_rst, ser_a, ser_b, ser_sum;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_ovf_s;

  serial_word_adder_driver #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .ser_rst(ser_rst), .ser_a(ser_a), .ser_b(ser_b), .ser_sum(ser_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry)
`ifdef SERIAL_WORD_ADDER_OVF_EN
    , .out_ovf(out_ovf_s)
`endif
  );
`ifndef SERIAL_WORD_ADDER_OVF_EN
  assign out_ovf_s = 1'b0;
`endif

  always #5 clk = ~clk;

  // External bit-serial adder: combinational sum, registered carry, sync clear
  logic carry_q;
  always @(posedge clk) begin
    if (ser_rst) carry_q <= 1'b0;
    else         carry_q <= (ser_a & ser_b) | (carry_q & (ser_a ^ ser_b));
  end
  assign ser_sum = ser_a ^ ser_b ^ carry_q;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t sbq[$];
  bit   head_seen = 0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   rand_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t e;
    int   s;
    int   sa, sb, ss;
    s  = int'(a) + int'(b);
    sa = (a >= 2**(W-1)) ? int'(a) - 2**W : int'(a);
    sb = (b >= 2**(W-1)) ? int'(b) - 2**W : int'(b);
    ss = sa + sb;
    e.sum   = W'(s % (2**W));
    e.carry = (s >= 2**W);
`ifdef SERIAL_WORD_ADDER_OVF_EN
    e.ovf   = (ss > 2**(W-1) - 1) || (ss < -(2**(W-1)));
`else
    e.ovf   = 1'b0;
`endif
    e.acc   = acc;
    return e;
  endfunction

  // Monitor: records accepted operands and checks every presented result
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      head_seen = 0;
    end else begin
      if (in_valid && in_ready) sbq.push_back(model(in_a, in_b, cyc + 1));
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("out_sum", 32'(out_sum), 32'(sbq[0].sum));
          chk("out_carry", 32'(out_carry), 32'(sbq[0].carry));
          chk("out_ovf", 32'(out_ovf_s), 32'(sbq[0].ovf));
          chk("in_ready_busy", 32'(in_ready), 32'd0);
          chk("ser_idle_bits", 32'({ser_a, ser_b}), 32'd0);
          if (!head_seen) chk("latency", 32'(cyc - sbq[0].acc), 32'(W + 1));
          head_seen = 1;
          if (out_ready) begin
            void'(sbq.pop_front());
            head_seen = 0;
          end
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) chk("drain_timeout", 32'(sbq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ser_rst", 32'(ser_rst), 32'd1);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_carry", 32'(out_carry), 32'd0);
    chk("rst_ser_rst_idle", 32'(ser_rst), 32'd1);

    send(8'h5A, 8'h33); drain();
    send(8'hFF, 8'h01); drain();
    send(8'h7F, 8'h01); drain();

    // Backpressure
    out_ready = 1'b0;
    send(8'h10, 8'h20);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_at_release", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
    chk("bp_idle_in_ready", 32'(in_ready), 32'd1);

    // Busy rejection: second operands waiting with in_valid high during SHIFT
    send(8'h0F, 8'h01);
    send(8'h80, 8'h80);
    drain();

    // Reset in SHIFT at cnt=3
    @(posedge clk); #1;
    in_a = 8'h12; in_b = 8'h34; in_valid = 1'b1;
    @(negedge clk);
    chk("rst_test_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ser_rst", 32'(ser_rst), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_ser_rst_after", 32'(ser_rst), 32'd1);
    send(8'h01, 8'h01); drain();

    // Random traffic with random backpressure
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(W'($urandom), W'($urandom));
    end
    rand_rdy = 0;
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
